// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module      : vga_timing_pkg
// Description : Standard raster mode constants (porch/sync/active per axis,
//               sync polarity) and helpers for derived line/frame totals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    typedef struct packed {
        int h_fp;
        int h_sw;
        int h_bp;
        int h_act;
        int v_fp;
        int v_sw;
        int v_bp;
        int v_act;
        bit h_pol;
        bit v_pol;
    } vga_mode_t;

    typedef enum logic [1:0] {
        MODE_SEL_640X480   = 2'd0,
        MODE_SEL_800X600   = 2'd1,
        MODE_SEL_1024X768  = 2'd2,
        MODE_SEL_1280X1024 = 2'd3
    } vga_mode_sel_e;

    localparam vga_mode_t MODE_640X480   = '{16, 96, 48, 640, 10, 2, 33, 480, 1'b0, 1'b0};
    localparam vga_mode_t MODE_800X600   = '{40, 128, 88, 800, 1, 4, 23, 600, 1'b1, 1'b1};
    localparam vga_mode_t MODE_1024X768  = '{24, 136, 160, 1024, 3, 6, 29, 768, 1'b0, 1'b0};
    localparam vga_mode_t MODE_1280X1024 = '{48, 112, 248, 1280, 1, 3, 38, 1024, 1'b1, 1'b1};

    function automatic int calc_blank(input int fp, input int sw, input int bp);
        return fp + sw + bp;
    endfunction

    function automatic int calc_total(input int fp, input int sw, input int bp, input int act);
        return calc_blank(fp, sw, bp) + act;
    endfunction

    function automatic vga_mode_t get_mode(input vga_mode_sel_e sel);
        case (sel)
            MODE_SEL_800X600:   return MODE_800X600;
            MODE_SEL_1024X768:  return MODE_1024X768;
            MODE_SEL_1280X1024: return MODE_1280X1024;
            default:            return MODE_640X480;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Raster timing bundle from the generator to renderer/DAC side.
//               frame_count exists only when VGA_TIMING_FRAME_CTR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_timing_gen_if #(
    parameter int HBITS = 10,
    parameter int VBITS = 10,
    parameter int FBITS = 8
);
    logic [VBITS-1:0] row;
    logic [HBITS-1:0] col;
    logic             line_start;
    logic             frame_start;
    logic             hsync;
    logic             vsync;
    logic             hblank;
    logic             vblank;
    logic             frame_active;
`ifdef VGA_TIMING_FRAME_CTR_EN
    logic [FBITS-1:0] frame_count;

    modport master (output row, col, line_start, frame_start, hsync, vsync,
                    hblank, vblank, frame_active, frame_count);
    modport slave  (input  row, col, line_start, frame_start, hsync, vsync,
                    hblank, vblank, frame_active, frame_count);
`else
    modport master (output row, col, line_start, frame_start, hsync, vsync,
                    hblank, vblank, frame_active);
    modport slave  (input  row, col, line_start, frame_start, hsync, vsync,
                    hblank, vblank, frame_active);
`endif

    if (FBITS < 1) begin : g_bad_fbits
        $error("vga_timing_gen_if: FBITS must be at least 1");
    end

endinterface

`default_nettype wire

// File: rtl/vga_delay_line.sv
// ============================================================================
// Module      : vga_delay_line
// Description : W-bit, D-stage register delay with synchronous reset to RST;
//               D=0 is a plain wire.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_delay_line #(
    parameter int           W   = 1,
    parameter int           D   = 0,
    parameter logic [W-1:0] RST = '0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic [W-1:0] i_d,
    output logic      [W-1:0] o_q
);

    if (D == 0) begin : g_pass
        logic w_unused;
        assign w_unused = clk ^ rst;
        assign o_q      = i_d;
    end else begin : g_pipe
        logic [W-1:0] r_stage [D];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < D; i++) r_stage[i] <= RST;
            end else begin
                r_stage[0] <= i_d;
                for (int i = 1; i < D; i++) r_stage[i] <= r_stage[i-1];
            end
        end

        assign o_q = r_stage[D-1];
    end

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised raster timing generator with registered decode,
//               strobes and a PIPE_DELAY-deep delayed sync/blank group.
//               Optional frame counter: define VGA_TIMING_FRAME_CTR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int HBITS         = 10,
    parameter int VBITS         = 10,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_WIDTH  = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int COLS          = 640,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_WIDTH  = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter int ROWS          = 480,
    parameter bit HSYNC_POL     = 1'b0,
    parameter bit VSYNC_POL     = 1'b0,
    parameter int PIPE_DELAY    = 0,
    parameter int FBITS         = 8
) (
    input  wire logic          dot_clock,
    input  wire logic          reset,
    vga_timing_gen_if.master   o_vga
);

    localparam int c_H_BLANK = calc_blank(H_FRONT_PORCH, H_SYNC_WIDTH, H_BACK_PORCH);
    localparam int c_H_TOTAL = calc_total(H_FRONT_PORCH, H_SYNC_WIDTH, H_BACK_PORCH, COLS);
    localparam int c_V_BLANK = calc_blank(V_FRONT_PORCH, V_SYNC_WIDTH, V_BACK_PORCH);
    localparam int c_V_TOTAL = calc_total(V_FRONT_PORCH, V_SYNC_WIDTH, V_BACK_PORCH, ROWS);

    if (c_H_TOTAL > 2**HBITS) begin : g_h_overflow
        $error("vga_timing_gen: H_TOTAL does not fit in HBITS");
    end
    if (c_V_TOTAL > 2**VBITS) begin : g_v_overflow
        $error("vga_timing_gen: V_TOTAL does not fit in VBITS");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_bad_delay
        $error("vga_timing_gen: PIPE_DELAY must be 0..15");
    end
    if (FBITS < 1) begin : g_bad_fbits
        $error("vga_timing_gen: FBITS must be at least 1");
    end

    localparam logic [HBITS-1:0] c_H_LAST     = HBITS'(c_H_TOTAL - 1);
    localparam logic [HBITS-1:0] c_H_BLANK_W  = HBITS'(c_H_BLANK);
    localparam logic [HBITS-1:0] c_HS_START   = HBITS'(H_FRONT_PORCH);
    localparam logic [HBITS-1:0] c_HS_END     = HBITS'(H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [VBITS-1:0] c_V_LAST     = VBITS'(c_V_TOTAL - 1);
    localparam logic [VBITS-1:0] c_V_BLANK_W  = VBITS'(c_V_BLANK);
    localparam logic [VBITS-1:0] c_VS_START   = VBITS'(V_FRONT_PORCH);
    localparam logic [VBITS-1:0] c_VS_END     = VBITS'(V_FRONT_PORCH + V_SYNC_WIDTH);
    // Delayed group order: {hsync, vsync, hblank, vblank, frame_active}
    localparam logic [4:0]       c_GRP_RST    = {!HSYNC_POL, !VSYNC_POL, 1'b1, 1'b1, 1'b0};

    logic [HBITS-1:0] r_h_ctr;
    logic [VBITS-1:0] r_v_ctr;
    logic [HBITS-1:0] r_col;
    logic [VBITS-1:0] r_row;
    logic             r_line_start;
    logic             r_frame_start;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_hblank;
    logic             r_vblank;
    logic             r_active;

    logic w_h_last;
    logic w_v_last;
    logic w_h_act;
    logic w_v_act;
    logic w_h_first;
    logic w_hs_on;
    logic w_vs_on;

    assign w_h_last  = (r_h_ctr == c_H_LAST);
    assign w_v_last  = (r_v_ctr == c_V_LAST);
    assign w_h_act   = (r_h_ctr >= c_H_BLANK_W);
    assign w_v_act   = (r_v_ctr >= c_V_BLANK_W);
    assign w_h_first = (r_h_ctr == c_H_BLANK_W);
    assign w_hs_on   = (r_h_ctr >= c_HS_START) && (r_h_ctr < c_HS_END);
    assign w_vs_on   = (r_v_ctr >= c_VS_START) && (r_v_ctr < c_VS_END);

    always_ff @(posedge dot_clock) begin
        if (reset) begin
            r_h_ctr       <= '0;
            r_v_ctr       <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_hsync       <= !HSYNC_POL;
            r_vsync       <= !VSYNC_POL;
            r_hblank      <= 1'b1;
            r_vblank      <= 1'b1;
            r_active      <= 1'b0;
        end else begin
            r_h_ctr <= w_h_last ? '0 : r_h_ctr + 1'b1;
            if (w_h_last) begin
                r_v_ctr <= w_v_last ? '0 : r_v_ctr + 1'b1;
            end
            r_col         <= w_h_act ? (r_h_ctr - c_H_BLANK_W) : '0;
            r_row         <= w_v_act ? (r_v_ctr - c_V_BLANK_W) : '0;
            r_line_start  <= w_h_first && w_v_act;
            r_frame_start <= w_h_first && (r_v_ctr == c_V_BLANK_W);
            r_hsync       <= w_hs_on ? HSYNC_POL : !HSYNC_POL;
            r_vsync       <= w_vs_on ? VSYNC_POL : !VSYNC_POL;
            r_hblank      <= !w_h_act;
            r_vblank      <= !w_v_act;
            r_active      <= w_h_act && w_v_act;
        end
    end

    logic [4:0] w_grp_dly;

    vga_delay_line #(
        .W   (5),
        .D   (PIPE_DELAY),
        .RST (c_GRP_RST)
    ) u_delay (
        .clk (dot_clock),
        .rst (reset),
        .i_d ({r_hsync, r_vsync, r_hblank, r_vblank, r_active}),
        .o_q (w_grp_dly)
    );

    assign o_vga.row          = r_row;
    assign o_vga.col          = r_col;
    assign o_vga.line_start   = r_line_start;
    assign o_vga.frame_start  = r_frame_start;
    assign o_vga.hsync        = w_grp_dly[4];
    assign o_vga.vsync        = w_grp_dly[3];
    assign o_vga.hblank       = w_grp_dly[2];
    assign o_vga.vblank       = w_grp_dly[1];
    assign o_vga.frame_active = w_grp_dly[0];

`ifdef VGA_TIMING_FRAME_CTR_EN
    logic [FBITS-1:0] r_frame_count;

    always_ff @(posedge dot_clock) begin
        if (reset) begin
            r_frame_count <= '0;
        end else if (r_frame_start) begin
            r_frame_count <= r_frame_count + 1'b1;
        end
    end

    assign o_vga.frame_count = r_frame_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench for vga_timing_gen in a 10x5 mode, comparing
//               a PIPE_DELAY=0 negative-sync DUT and a PIPE_DELAY=3 positive-sync DUT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

    localparam int HFP = 2, HSW = 3, HBP = 1, COLS = 4;
    localparam int VFP = 1, VSW = 1, VBP = 1, ROWS = 2;
    localparam int HB = HFP + HSW + HBP, HT = HB + COLS;
    localparam int VB = VFP + VSW + VBP, VT = VB + ROWS;
    localparam int FRAME = HT * VT;
    // Group bits: [4] hsync active, [3] vsync active, [2] hblank, [1] vblank, [0] frame_active
    localparam logic [4:0] GRP_RST = 5'b00110;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.HBITS(4), .VBITS(3), .FBITS(8)) vga0 ();
    vga_timing_gen_if #(.HBITS(4), .VBITS(3), .FBITS(8)) vga3 ();

    vga_timing_gen #(
        .HBITS(4), .VBITS(3),
        .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .H_BACK_PORCH(HBP), .COLS(COLS),
        .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW), .V_BACK_PORCH(VBP), .ROWS(ROWS),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_DELAY(0), .FBITS(8)
    ) u_dut0 (
        .dot_clock (clk),
        .reset     (reset),
        .o_vga     (vga0)
    );

    vga_timing_gen #(
        .HBITS(4), .VBITS(3),
        .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .H_BACK_PORCH(HBP), .COLS(COLS),
        .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW), .V_BACK_PORCH(VBP), .ROWS(ROWS),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_DELAY(3), .FBITS(8)
    ) u_dut3 (
        .dot_clock (clk),
        .reset     (reset),
        .o_vga     (vga3)
    );

    typedef struct {
        int         row;
        int         col;
        bit         ls;
        bit         fs;
        logic [4:0] grp;
        logic [4:0] dgrp;
        int         fc;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         done   = 1'b0;

    // Reference state: position within the frame and recent undelayed history.
    int         m_pos = 0;
    logic [4:0] m_hist [3];
    int         m_fc = 0;
    bit         m_prev_fs = 1'b0;

    task automatic model_step(input bit rst);
        exp_t e;
        int   h, v;
        bit   hb, vb;
        if (rst) begin
            e.row = 0; e.col = 0; e.ls = 1'b0; e.fs = 1'b0;
            e.grp = GRP_RST; e.dgrp = GRP_RST; e.fc = 0;
            for (int i = 0; i < 3; i++) m_hist[i] = GRP_RST;
            m_pos = 0; m_fc = 0; m_prev_fs = 1'b0;
        end else begin
            h  = m_pos % HT;
            v  = m_pos / HT;
            hb = (h < HB);
            vb = (v < VB);
            e.grp = {(h >= HFP) && (h < HFP + HSW), (v >= VFP) && (v < VFP + VSW),
                     hb, vb, !hb && !vb};
            e.col = hb ? 0 : h - HB;
            e.row = vb ? 0 : v - VB;
            e.ls  = (h == HB) && !vb;
            e.fs  = (h == HB) && (v == VB);
            e.dgrp = m_hist[2];
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = e.grp;
            m_fc = (m_fc + int'(m_prev_fs)) % 256;
            e.fc = m_fc;
            m_prev_fs = e.fs;
            m_pos = (m_pos + 1) % FRAME;
        end
        sb_q.push_back(e);
    endtask

    task automatic drive(input bit rst);
        @(posedge clk);
        #2;
        reset = rst;
        model_step(rst);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per sampled edge.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("d0_row",   32'(vga0.row),          32'(e.row));
                chk("d0_col",   32'(vga0.col),          32'(e.col));
                chk("d0_lstart",32'(vga0.line_start),   32'(e.ls));
                chk("d0_fstart",32'(vga0.frame_start),  32'(e.fs));
                chk("d0_hsync", 32'(vga0.hsync),        32'(!e.grp[4]));
                chk("d0_vsync", 32'(vga0.vsync),        32'(!e.grp[3]));
                chk("d0_hblank",32'(vga0.hblank),       32'(e.grp[2]));
                chk("d0_vblank",32'(vga0.vblank),       32'(e.grp[1]));
                chk("d0_active",32'(vga0.frame_active), 32'(e.grp[0]));
                chk("d3_row",   32'(vga3.row),          32'(e.row));
                chk("d3_col",   32'(vga3.col),          32'(e.col));
                chk("d3_lstart",32'(vga3.line_start),   32'(e.ls));
                chk("d3_fstart",32'(vga3.frame_start),  32'(e.fs));
                chk("d3_hsync", 32'(vga3.hsync),        32'(e.dgrp[4]));
                chk("d3_vsync", 32'(vga3.vsync),        32'(e.dgrp[3]));
                chk("d3_hblank",32'(vga3.hblank),       32'(e.dgrp[2]));
                chk("d3_vblank",32'(vga3.vblank),       32'(e.dgrp[1]));
                chk("d3_active",32'(vga3.frame_active), 32'(e.dgrp[0]));
`ifdef VGA_TIMING_FRAME_CTR_EN
                chk("d0_fcount",32'(vga0.frame_count),  32'(e.fc));
                chk("d3_fcount",32'(vga3.frame_count),  32'(e.fc));
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 3; i++) drive(1'b1);
        for (int i = 0; i < 2 * FRAME; i++) drive(1'b0);
        // Land inside the hsync pulse of line 2, then reset there.
        while (m_pos != 2 * HT + HFP + 1) drive(1'b0);
        drive(1'b1);
        drive(1'b1);
        for (int i = 0; i < FRAME + 7; i++) drive(1'b0);
        for (int seg = 0; seg < 40; seg++) begin
            int run_len;
            int rst_len;
            run_len = $urandom_range(1, 130);
            rst_len = $urandom_range(1, 3);
            for (int i = 0; i < run_len; i++) drive(1'b0);
            for (int i = 0; i < rst_len; i++) drive(1'b1);
        end
`ifdef VGA_TIMING_FRAME_CTR_EN
        for (int i = 0; i < 257 * FRAME + 20; i++) drive(1'b0);
`else
        for (int i = 0; i < 3 * FRAME; i++) drive(1'b0);
`endif
        @(posedge clk);
        #3;
        done = 1'b1;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
